axil_chan_slice: RTL and testbench

AXIL_CHAN_SLICE -- requirements
Module: axil_chan_slice

---
 rtl/axil_chan_slice_if.sv | 11 +
 rtl/axil_chan_slice.sv | 81 ++++++++
 tb/tb_axil_chan_slice.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_chan_slice_if.sv
// One valid/ready/data channel of an AXI4-Lite link, used on both sides of axil_chan_slice.
interface axil_chan_slice_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axil_chan_slice.sv
// Registered FIFO slice for any AXI4-Lite channel; fully decouples valid/data and ready paths.
// Optional stall-cycle counter port stall_cnt is built only when AXIL_SLICE_STATS_EN is defined.
module axil_chan_slice #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   axil_chan_slice_if.slave        s,
   axil_chan_slice_if.master       m,
`ifdef AXIL_SLICE_STATS_EN
   output logic [15:0]             stall_cnt,
`endif
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             r_init_done;

   logic             w_push;
   logic             w_pop;

   // Every output below depends only on flops, so no s_* -> m_* or m_ready -> s_ready path exists.
   assign s.ready = (r_count != CntW'(DEPTH)) && r_init_done;
   assign m.valid = (r_count != '0);
   assign m.data  = r_mem[r_rd_ptr];
   assign count   = r_count;

   assign w_push  = s.valid && s.ready;
   assign w_pop   = m.valid && m.ready;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_init_done <= 1'b1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; stale entries stay hidden because m.valid follows count.
   always_ff @(posedge ACLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s.data;
      end
   end

`ifdef AXIL_SLICE_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_stall_cnt <= '0;
      end else if (m.valid && !m.ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_axil_chan_slice.sv
// Self-checking bench for axil_chan_slice: reset, directed table, throughput, reset mid-stream,
// randomised scoreboard runs over several depths and (with AXIL_SLICE_STATS_EN) the stall counter.
module tb_axil_chan_slice;

   localparam int NI = 5;

   logic        clk;
   logic        rst_n;

   logic        tb_sv [NI];
   logic [31:0] tb_sd [NI];
   logic        tb_mr [NI];
   logic        w_mv  [NI];
   logic [31:0] w_md  [NI];
   logic        w_sr  [NI];
   logic [4:0]  w_cnt [NI];
`ifdef AXIL_SLICE_STATS_EN
   logic [15:0] w_stall [NI];
`endif

   int          errors;
   int          checks;
   int          cyc;
   int          pops;
   int          first_pop;
   int          last_pop;
   logic [31:0] sb [$];
   bit          prev_hold [NI];
   logic [31:0] prev_data [NI];

   typedef struct {
      bit          sv;
      logic [31:0] d;
      bit          mr;
      logic [4:0]  cnt;
      bit          mv;
      bit          sr;
      logic [31:0] md;
   } vec_t;

   vec_t tbl [15];

   // Instances 0..3 have DEPTH 2,4,8,16; instance 4 (DEPTH 2) is reserved for the stall counter.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned D = (g == 4) ? 2 : (2 << g);
      axil_chan_slice_if #(.WIDTH(32)) s_if ();
      axil_chan_slice_if #(.WIDTH(32)) m_if ();
      logic [$clog2(D):0] cnt;

      assign s_if.valid = tb_sv[g];
      assign s_if.data  = tb_sd[g];
      assign m_if.ready = tb_mr[g];
      assign w_mv[g]    = m_if.valid;
      assign w_md[g]    = m_if.data;
      assign w_sr[g]    = s_if.ready;
      assign w_cnt[g]   = 5'(cnt);

      axil_chan_slice #(
         .WIDTH(32),
         .DEPTH(D)
      ) u_dut (
         .ACLK     (clk),
         .ARESETn  (rst_n),
         .s        (s_if),
         .m        (m_if),
`ifdef AXIL_SLICE_STATS_EN
         .stall_cnt(w_stall[g]),
`endif
         .count    (cnt)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle on instance k: drive at the falling edge and score the handshake the next rising
   // edge will perform (outputs are register-driven, so they are already final here).
   task automatic step(input int k, input bit sv, input logic [31:0] d, input bit mr,
                       output bit acc);
      logic [31:0] exp;
      @(negedge clk);
      if (prev_hold[k]) begin
         chk("stable_valid", 32'(w_mv[k]), 32'd1);
         chk("stable_data", w_md[k], prev_data[k]);
      end
      tb_sv[k] = sv;
      tb_sd[k] = d;
      tb_mr[k] = mr;
      acc = sv && w_sr[k];
      if (acc) sb.push_back(d);
      if (w_mv[k] && mr) begin
         if (sb.size() == 0) begin
            chk("pop_nonempty_sb", 32'(sb.size()), 32'd1);
         end else begin
            exp = sb.pop_front();
            chk("pop_data", w_md[k], exp);
         end
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      prev_hold[k] = w_mv[k] && !mr;
      prev_data[k] = w_md[k];
      cyc++;
   endtask

   task automatic rand_run(input int k, input int nbeats);
      bit          acc;
      bit          sv_cur;
      logic [31:0] d_cur;
      int          pushed;
      sb.delete();
      pops = 0;
      pushed = 0;
      acc = 1'b0;
      sv_cur = 1'b0;
      d_cur = '0;
      prev_hold[k] = 1'b0;
      for (int c = 0; c < 20 * nbeats && pops < nbeats; c++) begin
         if (!sv_cur || acc) begin
            if (pushed < nbeats && $urandom_range(0, 1) == 1) begin
               sv_cur = 1'b1;
               d_cur = $urandom;
            end else begin
               sv_cur = 1'b0;
            end
         end
         step(k, sv_cur, d_cur, ($urandom_range(0, 1) == 1), acc);
         if (acc) pushed++;
      end
      tb_sv[k] = 1'b0;
      tb_mr[k] = 1'b0;
      chk($sformatf("rand_pops_k%0d", k), 32'(pops), 32'(nbeats));
      chk($sformatf("rand_sb_empty_k%0d", k), 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      errors = 0;
      checks = 0;
      cyc = 0;
      // {s_valid, s_data, m_ready} -> {count, m_valid, s_ready, m_data} after the edge, DEPTH=4.
      tbl[0]  = '{1'b1, 32'd1, 1'b0, 5'd1, 1'b1, 1'b1, 32'd1};
      tbl[1]  = '{1'b1, 32'd2, 1'b0, 5'd2, 1'b1, 1'b1, 32'd1};
      tbl[2]  = '{1'b1, 32'd3, 1'b0, 5'd3, 1'b1, 1'b1, 32'd1};
      tbl[3]  = '{1'b1, 32'd4, 1'b0, 5'd4, 1'b1, 1'b0, 32'd1};
      tbl[4]  = '{1'b1, 32'd5, 1'b0, 5'd4, 1'b1, 1'b0, 32'd1};
      tbl[5]  = '{1'b1, 32'd5, 1'b1, 5'd3, 1'b1, 1'b1, 32'd2};
      tbl[6]  = '{1'b1, 32'd5, 1'b0, 5'd4, 1'b1, 1'b0, 32'd2};
      tbl[7]  = '{1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 1'b1, 32'd3};
      tbl[8]  = '{1'b1, 32'd6, 1'b1, 5'd3, 1'b1, 1'b1, 32'd4};
      tbl[9]  = '{1'b0, 32'd0, 1'b1, 5'd2, 1'b1, 1'b1, 32'd5};
      tbl[10] = '{1'b0, 32'd0, 1'b1, 5'd1, 1'b1, 1'b1, 32'd6};
      tbl[11] = '{1'b0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1, 32'd0};
      tbl[12] = '{1'b0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1, 32'd0};
      tbl[13] = '{1'b1, 32'd7, 1'b1, 5'd1, 1'b1, 1'b1, 32'd7};
      tbl[14] = '{1'b0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b1, 32'd0};

      for (int k = 0; k < NI; k++) begin
         tb_sv[k] = 1'b0;
         tb_sd[k] = '0;
         tb_mr[k] = 1'b0;
         prev_hold[k] = 1'b0;
         prev_data[k] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_m_valid_k%0d", k), 32'(w_mv[k]), 32'd0);
         chk($sformatf("rst_s_ready_k%0d", k), 32'(w_sr[k]), 32'd0);
         chk($sformatf("rst_count_k%0d", k), 32'(w_cnt[k]), 32'd0);
      end
      rst_n = 1'b1;
      chk("release_s_ready_low", 32'(w_sr[1]), 32'd0);
      @(negedge clk);
      chk("release_s_ready_high", 32'(w_sr[1]), 32'd1);
      chk("release_count", 32'(w_cnt[1]), 32'd0);

      // Fill, full hold-off, full with m_ready, simultaneous push/pop, empty pop on DEPTH=4.
      for (int i = 0; i < 15; i++) begin
         tb_sv[1] = tbl[i].sv;
         tb_sd[1] = tbl[i].d;
         tb_mr[1] = tbl[i].mr;
         @(negedge clk);
         chk($sformatf("tbl%0d_count", i), 32'(w_cnt[1]), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_m_valid", i), 32'(w_mv[1]), 32'(tbl[i].mv));
         chk($sformatf("tbl%0d_s_ready", i), 32'(w_sr[1]), 32'(tbl[i].sr));
         if (tbl[i].mv) chk($sformatf("tbl%0d_m_data", i), w_md[1], tbl[i].md);
      end
      tb_sv[1] = 1'b0;
      tb_mr[1] = 1'b0;

      // Streaming through DEPTH=2 with m_ready held high: one beat per cycle.
      sb.delete();
      pops = 0;
      first_pop = -1;
      last_pop = -1;
      for (int i = 1; i <= 16; i++) begin
         step(0, 1'b1, 32'hA5A5_0000 + 32'(i), 1'b1, acc);
         chk($sformatf("stream_accept_%0d", i), 32'(acc), 32'd1);
         chk($sformatf("stream_count_le1_%0d", i), 32'(w_cnt[0] <= 5'd1), 32'd1);
      end
      for (int i = 0; i < 8 && sb.size() != 0; i++) step(0, 1'b0, 32'd0, 1'b1, acc);
      chk("stream_pops", 32'(pops), 32'd16);
      chk("stream_back_to_back", 32'(last_pop - first_pop), 32'd15);
      chk("stream_sb_empty", 32'(sb.size()), 32'd0);
      tb_mr[0] = 1'b0;

      // Reset with three beats held on DEPTH=4: nothing stale may appear afterwards.
      step(1, 1'b1, 32'h11, 1'b0, acc);
      step(1, 1'b1, 32'h22, 1'b0, acc);
      step(1, 1'b1, 32'h33, 1'b0, acc);
      @(negedge clk);
      tb_sv[1] = 1'b0;
      chk("midrst_count_before", 32'(w_cnt[1]), 32'd3);
      rst_n = 1'b0;
      tb_mr[1] = 1'b1;
      @(negedge clk);
      chk("midrst_m_valid", 32'(w_mv[1]), 32'd0);
      chk("midrst_count", 32'(w_cnt[1]), 32'd0);
      chk("midrst_s_ready", 32'(w_sr[1]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready_after", 32'(w_sr[1]), 32'd1);
      chk("midrst_no_stale", 32'(w_mv[1]), 32'd0);
      tb_sv[1] = 1'b1;
      tb_sd[1] = 32'h44;
      tb_mr[1] = 1'b0;
      @(negedge clk);
      tb_sv[1] = 1'b0;
      chk("midrst_new_valid", 32'(w_mv[1]), 32'd1);
      chk("midrst_new_data", w_md[1], 32'h44);
      chk("midrst_new_count", 32'(w_cnt[1]), 32'd1);
      tb_mr[1] = 1'b1;
      @(negedge clk);
      chk("midrst_drained", 32'(w_mv[1]), 32'd0);
      tb_mr[1] = 1'b0;
      sb.delete();

      fork
         begin
            rand_run(0, 4000);
            rand_run(2, 4000);
            rand_run(3, 4000);
         end
`ifdef AXIL_SLICE_STATS_EN
         begin
            @(negedge clk);
            tb_sv[4] = 1'b1;
            tb_sd[4] = 32'h5;
            tb_mr[4] = 1'b0;
            @(negedge clk);
            tb_sv[4] = 1'b0;
            chk("stall_start", 32'(w_stall[4]), 32'd0);
            chk("stall_m_valid", 32'(w_mv[4]), 32'd1);
            repeat (10) @(negedge clk);
            chk("stall_10", 32'(w_stall[4]), 32'd10);
            repeat (70000) @(negedge clk);
            chk("stall_sat", 32'(w_stall[4]), 32'h0000_FFFF);
            tb_mr[4] = 1'b1;
            @(negedge clk);
            tb_mr[4] = 1'b0;
            chk("stall_hold", 32'(w_stall[4]), 32'h0000_FFFF);
         end
`endif
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
